// File: rtl/game_timer_bcd_pkg.sv
// rtl/game_timer_bcd_pkg.sv - shared limits and digit helpers for the BCD game timer
package game_timer_bcd_pkg;

  localparam logic [3:0]  SS_TENS_MAX     = 4'd5;
  localparam logic [3:0]  DIGIT_MAX       = 4'd9;
  localparam logic [15:0] TIME_MAX        = 16'h9959;
  localparam logic [15:0] TIME_ZERO       = 16'h0000;
  // Values one count step away from a limit; used to flag expiry a cycle early
  localparam logic [15:0] TIME_ONE        = 16'h0001;
  localparam logic [15:0] TIME_BEFORE_MAX = 16'h9958;

  // Clamp a raw preset nibble so it never exceeds the digit's legal maximum
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one mod-(MAX+1) up/down BCD digit with clear, load and carry/borrow out
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  input  logic       down_i,
  output logic [3:0] digit_o,
  output logic       carry_o
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;
  logic       at_edge;

  // Digit sits at the value that rolls over in the current direction
  assign at_edge = down_i ? (digit_q == 4'd0) : (digit_q == MAX);
  // Carry/borrow is combinational so the whole chain steps within one edge
  assign carry_o = en_i & at_edge;
  assign digit_o = digit_q;

  // Next digit value: clear beats load beats step beats hold
  always_comb begin
    digit_d = digit_q;
    if (clear_i) begin
      digit_d = 4'd0;
    end else if (load_i) begin
      digit_d = load_val_i;
    end else if (en_i) begin
      if (down_i) begin
        digit_d = at_edge ? MAX : (digit_q - 4'd1);
      end else begin
        digit_d = at_edge ? 4'd0 : (digit_q + 4'd1);
      end
    end
  end

  // Digit register with asynchronous reset to zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/game_timer_bcd.sv
// rtl/game_timer_bcd.sv - MM:SS BCD stopwatch/countdown timer with saturate or wrap up-count
module game_timer_bcd
  import game_timer_bcd_pkg::*;
#(
  parameter int SATURATE = 1
) (
  input  logic        clk_sec,
  input  logic        rst,
  input  logic        run,
  input  logic        clear,
  input  logic        load,
  input  logic        mode_down,
  input  logic [15:0] preset,
  output logic [15:0] time_bcd,
  output logic        at_limit,
  output logic        running,
  output logic        expired
);

  logic [15:0] preset_clamped;
  logic        count_en;
  logic        c_ss_ones;
  logic        c_ss_tens;
  logic        c_mm_ones;
  logic        c_mm_tens;
  logic        expired_q;
  logic        expired_d;
  logic [3:0]  d_ss_ones;
  logic [3:0]  d_ss_tens;
  logic [3:0]  d_mm_ones;
  logic [3:0]  d_mm_tens;

  // Out-of-range preset digits are pulled to the nearest legal value
  assign preset_clamped = {clamp_digit(preset[15:12], DIGIT_MAX),
                           clamp_digit(preset[11:8],  DIGIT_MAX),
                           clamp_digit(preset[7:4],   SS_TENS_MAX),
                           clamp_digit(preset[3:0],   DIGIT_MAX)};

  assign time_bcd = {d_mm_tens, d_mm_ones, d_ss_tens, d_ss_ones};

  // Limit depends on mode; wrap-mode up-count has no limit
  assign at_limit = (mode_down && (time_bcd == TIME_ZERO)) ||
                    (!mode_down && (SATURATE != 0) && (time_bcd == TIME_MAX));
  assign running  = run & ~at_limit;
  assign count_en = run & ~clear & ~load & ~at_limit;
  assign expired  = expired_q;

  bcd_digit #(.MAX(DIGIT_MAX)) u_ss_ones (
    .clk_i(clk_sec), .rst_i(rst), .clear_i(clear), .load_i(load),
    .load_val_i(preset_clamped[3:0]), .en_i(count_en), .down_i(mode_down),
    .digit_o(d_ss_ones), .carry_o(c_ss_ones)
  );

  bcd_digit #(.MAX(SS_TENS_MAX)) u_ss_tens (
    .clk_i(clk_sec), .rst_i(rst), .clear_i(clear), .load_i(load),
    .load_val_i(preset_clamped[7:4]), .en_i(c_ss_ones), .down_i(mode_down),
    .digit_o(d_ss_tens), .carry_o(c_ss_tens)
  );

  bcd_digit #(.MAX(DIGIT_MAX)) u_mm_ones (
    .clk_i(clk_sec), .rst_i(rst), .clear_i(clear), .load_i(load),
    .load_val_i(preset_clamped[11:8]), .en_i(c_ss_tens), .down_i(mode_down),
    .digit_o(d_mm_ones), .carry_o(c_mm_ones)
  );

  bcd_digit #(.MAX(DIGIT_MAX)) u_mm_tens (
    .clk_i(clk_sec), .rst_i(rst), .clear_i(clear), .load_i(load),
    .load_val_i(preset_clamped[15:12]), .en_i(c_mm_ones), .down_i(mode_down),
    .digit_o(d_mm_tens), .carry_o(c_mm_tens)
  );

  // Expiry is decided from the pre-step value so the pulse aligns with the new time;
  // down mode can never borrow past zero because at_limit blocks counting there
  always_comb begin
    expired_d = 1'b0;
    if (count_en) begin
      if (mode_down) begin
        expired_d = (time_bcd == TIME_ONE);
      end else if (SATURATE != 0) begin
        expired_d = (time_bcd == TIME_BEFORE_MAX);
      end else begin
        expired_d = c_mm_tens;
      end
    end
  end

  // One-cycle expiry pulse register
  always_ff @(posedge clk_sec or posedge rst) begin
    if (rst) begin
      expired_q <= 1'b0;
    end else begin
      expired_q <= expired_d;
    end
  end

endmodule

// File: tb/tb_game_timer_bcd.sv
// tb/tb_game_timer_bcd.sv - directed self-checking bench for game_timer_bcd
module tb_game_timer_bcd;

  logic        clk_sec;
  logic        rst;
  logic        run;
  logic        clear;
  logic        load;
  logic        mode_down;
  logic [15:0] preset;
  logic [15:0] t_s, t_w;
  logic        al_s, al_w, rn_s, rn_w, ex_s, ex_w;
  int          total;
  int          bad;

  game_timer_bcd #(.SATURATE(1)) dut_s (
    .clk_sec(clk_sec), .rst(rst), .run(run), .clear(clear), .load(load),
    .mode_down(mode_down), .preset(preset), .time_bcd(t_s),
    .at_limit(al_s), .running(rn_s), .expired(ex_s)
  );

  game_timer_bcd #(.SATURATE(0)) dut_w (
    .clk_sec(clk_sec), .rst(rst), .run(run), .clear(clear), .load(load),
    .mode_down(mode_down), .preset(preset), .time_bcd(t_w),
    .at_limit(al_w), .running(rn_w), .expired(ex_w)
  );

  initial begin
    clk_sec = 1'b0;
    forever #5 clk_sec = ~clk_sec;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sec);
      @(negedge clk_sec);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; run = 1'b0; clear = 1'b0; load = 1'b0; mode_down = 1'b0; preset = 16'h0;
    #1;
    total++; if (t_s !== 16'h0000) begin bad++; $display("FAIL reset_time got=%h want=0000", t_s); end
    total++; if (ex_s !== 1'b0) begin bad++; $display("FAIL reset_expired got=%b want=0", ex_s); end
    total++; if (al_s !== 1'b0) begin bad++; $display("FAIL reset_limit_up got=%b want=0", al_s); end
    mode_down = 1'b1; #1;
    total++; if (al_s !== 1'b1) begin bad++; $display("FAIL reset_limit_down got=%b want=1", al_s); end
    run = 1'b1; #1;
    total++; if (rn_s !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", rn_s); end
    run = 1'b0; mode_down = 1'b0;
    @(negedge clk_sec);
    rst = 1'b0;
  endtask

  task automatic test_up_count;
    mode_down = 1'b0; run = 1'b1;
    for (int i = 0; i < 75; i++) begin
      tick(1);
      total++; if (ex_s !== 1'b0 || ex_w !== 1'b0) begin bad++; $display("FAIL up75_expired edge=%0d got=%b%b want=00", i, ex_s, ex_w); end
    end
    total++; if (t_s !== 16'h0115) begin bad++; $display("FAIL up75_time_sat got=%h want=0115", t_s); end
    total++; if (t_w !== 16'h0115) begin bad++; $display("FAIL up75_time_wrap got=%h want=0115", t_w); end
    total++; if (rn_s !== 1'b1) begin bad++; $display("FAIL up75_running got=%b want=1", rn_s); end
    run = 1'b0;
  endtask

  task automatic test_saturate;
    mode_down = 1'b0; load = 1'b1; preset = 16'h9958;
    tick(1);
    load = 1'b0;
    total++; if (t_s !== 16'h9958) begin bad++; $display("FAIL sat_load got=%h want=9958", t_s); end
    total++; if (al_s !== 1'b0) begin bad++; $display("FAIL sat_limit_pre got=%b want=0", al_s); end
    run = 1'b1;
    tick(1);
    total++; if (t_s !== 16'h9959) begin bad++; $display("FAIL sat_edge1 got=%h want=9959", t_s); end
    total++; if (ex_s !== 1'b1) begin bad++; $display("FAIL sat_expired1 got=%b want=1", ex_s); end
    total++; if (al_s !== 1'b1) begin bad++; $display("FAIL sat_limit got=%b want=1", al_s); end
    total++; if (rn_s !== 1'b0) begin bad++; $display("FAIL sat_running got=%b want=0", rn_s); end
    tick(1);
    total++; if (t_s !== 16'h9959) begin bad++; $display("FAIL sat_edge2 got=%h want=9959", t_s); end
    total++; if (ex_s !== 1'b0) begin bad++; $display("FAIL sat_expired2 got=%b want=0", ex_s); end
    tick(1);
    total++; if (t_s !== 16'h9959 || ex_s !== 1'b0) begin bad++; $display("FAIL sat_edge3 got=%h/%b want=9959/0", t_s, ex_s); end
    run = 1'b0;
  endtask

  task automatic test_down;
    mode_down = 1'b1; load = 1'b1; preset = 16'h0100;
    tick(1);
    load = 1'b0;
    total++; if (al_s !== 1'b0) begin bad++; $display("FAIL down_limit_pre got=%b want=0", al_s); end
    run = 1'b1;
    tick(1);
    total++; if (t_s !== 16'h0059) begin bad++; $display("FAIL down_edge1 got=%h want=0059", t_s); end
    tick(58);
    total++; if (t_s !== 16'h0001 || ex_s !== 1'b0) begin bad++; $display("FAIL down_edge59 got=%h/%b want=0001/0", t_s, ex_s); end
    tick(1);
    total++; if (t_s !== 16'h0000) begin bad++; $display("FAIL down_zero got=%h want=0000", t_s); end
    total++; if (ex_s !== 1'b1 || ex_w !== 1'b1) begin bad++; $display("FAIL down_expired got=%b%b want=11", ex_s, ex_w); end
    total++; if (al_s !== 1'b1 || rn_s !== 1'b0) begin bad++; $display("FAIL down_limit got=%b/%b want=1/0", al_s, rn_s); end
    tick(1);
    total++; if (t_s !== 16'h0000 || ex_s !== 1'b0) begin bad++; $display("FAIL down_hold got=%h/%b want=0000/0", t_s, ex_s); end
    run = 1'b0;
  endtask

  task automatic test_clamp_clear;
    mode_down = 1'b0; load = 1'b1; preset = 16'hAB7C;
    tick(1);
    total++; if (t_s !== 16'h9959) begin bad++; $display("FAIL clamp got=%h want=9959", t_s); end
    total++; if (ex_s !== 1'b0 || al_s !== 1'b1) begin bad++; $display("FAIL clamp_flags got=%b/%b want=0/1", ex_s, al_s); end
    clear = 1'b1; preset = 16'h1234;
    tick(1);
    total++; if (t_s !== 16'h0000) begin bad++; $display("FAIL clear_over_load got=%h want=0000", t_s); end
    clear = 1'b0; mode_down = 1'b1; preset = 16'h0005;
    tick(1);
    total++; if (t_s !== 16'h0005) begin bad++; $display("FAIL load_0005 got=%h want=0005", t_s); end
    load = 1'b0; clear = 1'b1; run = 1'b1;
    tick(1);
    total++; if (t_s !== 16'h0000 || ex_s !== 1'b0) begin bad++; $display("FAIL clear_no_expire got=%h/%b want=0000/0", t_s, ex_s); end
    clear = 1'b0; run = 1'b0; mode_down = 1'b0;
  endtask

  task automatic test_async_reset;
    mode_down = 1'b0; load = 1'b1; preset = 16'h1234;
    tick(1);
    load = 1'b0; run = 1'b1;
    tick(1);
    total++; if (t_s !== 16'h1235) begin bad++; $display("FAIL arst_pre got=%h want=1235", t_s); end
    #2 rst = 1'b1;
    #1;
    total++; if (t_s !== 16'h0000 || ex_s !== 1'b0) begin bad++; $display("FAIL arst_now got=%h/%b want=0000/0", t_s, ex_s); end
    run = 1'b0;
    #1 rst = 1'b0;
    tick(1);
    total++; if (t_s !== 16'h0000) begin bad++; $display("FAIL arst_norun got=%h want=0000", t_s); end
    run = 1'b1;
    tick(1);
    total++; if (t_s !== 16'h0001) begin bad++; $display("FAIL arst_run got=%h want=0001", t_s); end
    run = 1'b0;
  endtask

  task automatic test_wrap;
    mode_down = 1'b0; load = 1'b1; preset = 16'h9959;
    tick(1);
    load = 1'b0;
    total++; if (t_w !== 16'h9959 || al_w !== 1'b0 || ex_w !== 1'b0) begin bad++; $display("FAIL wrap_load got=%h/%b/%b want=9959/0/0", t_w, al_w, ex_w); end
    run = 1'b1;
    tick(1);
    total++; if (t_w !== 16'h0000) begin bad++; $display("FAIL wrap_time got=%h want=0000", t_w); end
    total++; if (ex_w !== 1'b1 || al_w !== 1'b0 || rn_w !== 1'b1) begin bad++; $display("FAIL wrap_flags got=%b/%b/%b want=1/0/1", ex_w, al_w, rn_w); end
    total++; if (t_s !== 16'h9959 || ex_s !== 1'b0) begin bad++; $display("FAIL wrap_sat_hold got=%h/%b want=9959/0", t_s, ex_s); end
    #2 rst = 1'b1;
    #1;
    total++; if (ex_w !== 1'b0 || t_w !== 16'h0000) begin bad++; $display("FAIL wrap_arst got=%b/%h want=0/0000", ex_w, t_w); end
    run = 1'b0;
    #1 rst = 1'b0;
    tick(1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_up_count();
    test_saturate();
    test_down();
    test_clamp_clear();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
